// File: rtl/pipe_skid_stage_if.sv
// ============================================================================
//  Module      : pipe_skid_stage_if
//  Description : Handshake bundle for one pipeline stage. The upstream side
//                carries in_valid/in_ready/in_data and the downstream side
//                carries out_valid/out_ready/out_data.
//                slave  = the stage itself.
//                master = the environment that feeds and drains the stage.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface pipe_skid_stage_if #(
    parameter int WIDTH = 160
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;

    modport slave (
        input  in_valid,
        input  in_data,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_data
    );

    modport master (
        output in_valid,
        output in_data,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_data
    );
endinterface

`default_nettype wire

// File: rtl/pipe_skid_stage.sv
// ============================================================================
//  Module      : pipe_skid_stage
//  Description : Inter-stage pipeline register with a valid/ready handshake,
//                a 2-entry skid buffer (main + skid) and a synchronous flush.
//                in_ready is registered, so back-pressure moves upstream one
//                stage per cycle without a combinational ready chain.
//                A saturating counter records cycles stalled by downstream.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pipe_skid_stage #(
    parameter int               WIDTH  = 160,
    parameter logic [WIDTH-1:0] BUBBLE = '0,
    parameter int               CNT_W  = 16
) (
    input  wire logic             clk,
    input  wire logic             reset,     // synchronous, active-low
    input  wire logic             flush,
    pipe_skid_stage_if.slave      bus,
    output      logic [CNT_W-1:0] stall_cnt
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] c_CNT_MAX = '1;
    localparam logic [CNT_W-1:0] c_CNT_ONE = CNT_W'(1);

    state_t           r_state;
    logic [WIDTH-1:0] r_main;
    logic [WIDTH-1:0] r_skid;
    logic             r_out_valid;
    logic             r_in_ready;
    logic [CNT_W-1:0] r_stall_cnt;

    logic w_accept;
    logic w_emit;
    logic w_stall;

    assign w_accept = bus.in_valid  & r_in_ready;
    assign w_emit   = r_out_valid   & bus.out_ready;
    assign w_stall  = r_out_valid   & ~bus.out_ready;

    assign bus.in_ready  = r_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.out_data  = r_main;
    assign stall_cnt     = r_stall_cnt;

    // Occupancy FSM: moves payloads between upstream, skid and main registers
    // and registers the handshake outputs alongside the next state.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state     <= ST_EMPTY;
            r_main      <= BUBBLE;
            r_skid      <= BUBBLE;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
        end else if (flush) begin
            // Squash: any same-cycle accept is dropped; an emit already
            // happened downstream because out_data was valid this cycle.
            r_state     <= ST_EMPTY;
            r_main      <= BUBBLE;
            r_skid      <= BUBBLE;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
        end else begin
            case (r_state)
                ST_EMPTY: begin
                    if (w_accept) begin
                        r_main      <= bus.in_data;
                        r_state     <= ST_ONE;
                        r_out_valid <= 1'b1;
                        r_in_ready  <= 1'b1;
                    end
                end
                ST_ONE: begin
                    if (w_accept && w_emit) begin
                        r_main <= bus.in_data;
                    end else if (w_accept) begin
                        // Downstream stalled: park the new word in the skid
                        // register and drop ready for the next cycle.
                        r_skid     <= bus.in_data;
                        r_state    <= ST_FULL;
                        r_in_ready <= 1'b0;
                    end else if (w_emit) begin
                        r_main      <= BUBBLE;
                        r_state     <= ST_EMPTY;
                        r_out_valid <= 1'b0;
                    end
                end
                ST_FULL: begin
                    // in_ready is low here, so no accept can coincide.
                    if (w_emit) begin
                        r_main     <= r_skid;
                        r_skid     <= BUBBLE;
                        r_state    <= ST_ONE;
                        r_in_ready <= 1'b1;
                    end
                end
                default: begin
                    r_state     <= ST_EMPTY;
                    r_main      <= BUBBLE;
                    r_skid      <= BUBBLE;
                    r_out_valid <= 1'b0;
                    r_in_ready  <= 1'b1;
                end
            endcase
        end
    end

    // Saturating stall counter; flush leaves it alone, only reset clears it.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_stall_cnt <= '0;
        end else if (w_stall && (r_stall_cnt != c_CNT_MAX)) begin
            r_stall_cnt <= r_stall_cnt + c_CNT_ONE;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_pipe_skid_stage.sv
// ============================================================================
//  Module      : tb_pipe_skid_stage
//  Description : Directed self-checking bench for pipe_skid_stage. One
//                default-width instance covers reset, streaming, skid
//                back-pressure, flush and reset-in-FULL; a second instance
//                with a 4-bit counter covers stall counter saturation.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pipe_skid_stage;

    localparam int WIDTH = 160;

    logic clk;
    logic m_reset;
    logic m_flush;
    logic [15:0] m_cnt;
    logic s_reset;
    logic s_flush;
    logic [3:0]  s_cnt;

    int errors;
    int checks;

    pipe_skid_stage_if #(.WIDTH(WIDTH)) m_bus ();
    pipe_skid_stage_if #(.WIDTH(WIDTH)) s_bus ();

    pipe_skid_stage #(.WIDTH(WIDTH), .BUBBLE('0), .CNT_W(16)) u_dut (
        .clk       (clk),
        .reset     (m_reset),
        .flush     (m_flush),
        .bus       (m_bus),
        .stall_cnt (m_cnt)
    );

    pipe_skid_stage #(.WIDTH(WIDTH), .BUBBLE('0), .CNT_W(4)) u_sat (
        .clk       (clk),
        .reset     (s_reset),
        .flush     (s_flush),
        .bus       (s_bus),
        .stall_cnt (s_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [WIDTH-1:0] pay(input logic [31:0] base, input int k);
        logic [31:0] w;
        w = base + 32'(k);
        return {5{w}};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [WIDTH-1:0] obs, input logic [WIDTH-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;

        // ---------------- reset, with in_valid held high ----------------
        m_reset = 1'b0; m_flush = 1'b0;
        m_bus.in_valid = 1'b1; m_bus.in_data = pay(32'hA000_0000, 1); m_bus.out_ready = 1'b1;
        s_reset = 1'b0; s_flush = 1'b0;
        s_bus.in_valid = 1'b0; s_bus.in_data = '0; s_bus.out_ready = 1'b0;
        tick();
        tick();
        check("rst_out_valid", WIDTH'(m_bus.out_valid), '0);
        check("rst_out_data",  m_bus.out_data, '0);
        check("rst_in_ready",  WIDTH'(m_bus.in_ready), WIDTH'(1));
        check("rst_stall_cnt", WIDTH'(m_cnt), '0);

        // First accept happens on the first edge with reset released.
        m_reset = 1'b1;
        tick();
        check("first_valid", WIDTH'(m_bus.out_valid), WIDTH'(1));
        check("first_data",  m_bus.out_data, pay(32'hA000_0000, 1));

        // ---------------- streaming A2..A8 ----------------
        for (int k = 2; k <= 8; k++) begin
            m_bus.in_data = pay(32'hA000_0000, k);
            tick();
            check($sformatf("stream_data_%0d", k), m_bus.out_data, pay(32'hA000_0000, k));
            check($sformatf("stream_ready_%0d", k), WIDTH'(m_bus.in_ready), WIDTH'(1));
        end
        m_bus.in_valid = 1'b0;
        tick();
        check("stream_drain_valid", WIDTH'(m_bus.out_valid), '0);
        check("stream_drain_data",  m_bus.out_data, '0);
        check("stream_stall_cnt",   WIDTH'(m_cnt), '0);

        // ---------------- back-pressure into skid ----------------
        m_bus.in_valid = 1'b1; m_bus.in_data = pay(32'hB000_0000, 1);
        tick();                                            // ONE: M=A1
        check("bp_a1_out", m_bus.out_data, pay(32'hB000_0000, 1));
        m_bus.out_ready = 1'b0; m_bus.in_data = pay(32'hB000_0000, 2);
        tick();                                            // FULL: S=A2, cnt=1
        check("bp_full_hold",  m_bus.out_data, pay(32'hB000_0000, 1));
        check("bp_full_ready", WIDTH'(m_bus.in_ready), '0);
        m_bus.in_data = pay(32'hB000_0000, 3);
        tick();                                            // hold, cnt=2
        tick();                                            // hold, cnt=3
        check("bp_a3_ignored", m_bus.out_data, pay(32'hB000_0000, 1));
        check("bp_cnt_stalled", WIDTH'(m_cnt), WIDTH'(3));
        m_bus.out_ready = 1'b1;
        tick();                                            // emit A1, M=A2
        check("bp_a2_out",   m_bus.out_data, pay(32'hB000_0000, 2));
        check("bp_ready_up", WIDTH'(m_bus.in_ready), WIDTH'(1));
        tick();                                            // emit A2, accept A3
        check("bp_a3_out", m_bus.out_data, pay(32'hB000_0000, 3));
        m_bus.in_valid = 1'b0;
        tick();
        check("bp_empty_valid", WIDTH'(m_bus.out_valid), '0);
        check("bp_cnt_final",   WIDTH'(m_cnt), WIDTH'(3));

        // ---------------- flush while FULL ----------------
        m_bus.in_valid = 1'b1; m_bus.in_data = pay(32'hC000_0000, 1); m_bus.out_ready = 1'b0;
        tick();                                            // ONE: M=A1
        m_bus.in_data = pay(32'hC000_0000, 2);
        tick();                                            // FULL, cnt=4
        check("fl_full_ready", WIDTH'(m_bus.in_ready), '0);
        m_flush = 1'b1; m_bus.out_ready = 1'b1; m_bus.in_data = pay(32'hC000_0000, 3);
        tick();                                            // A1 emitted, rest squashed
        check("fl_valid", WIDTH'(m_bus.out_valid), '0);
        check("fl_data",  m_bus.out_data, '0);
        check("fl_ready", WIDTH'(m_bus.in_ready), WIDTH'(1));
        check("fl_cnt",   WIDTH'(m_cnt), WIDTH'(4));
        m_flush = 1'b0; m_bus.in_valid = 1'b0;
        tick();
        tick();
        check("fl_no_ghost", WIDTH'(m_bus.out_valid), '0);

        // ---------------- reset while FULL ----------------
        m_bus.in_valid = 1'b1; m_bus.in_data = pay(32'hD000_0000, 1); m_bus.out_ready = 1'b0;
        tick();
        m_bus.in_data = pay(32'hD000_0000, 2);
        tick();                                            // FULL, cnt=5
        check("rf_full_cnt", WIDTH'(m_cnt), WIDTH'(5));
        m_reset = 1'b0; m_bus.in_valid = 1'b0;
        tick();
        check("rf_valid", WIDTH'(m_bus.out_valid), '0);
        check("rf_ready", WIDTH'(m_bus.in_ready), WIDTH'(1));
        check("rf_cnt",   WIDTH'(m_cnt), '0);
        m_reset = 1'b1; m_bus.in_valid = 1'b1; m_bus.in_data = pay(32'hE000_0000, 1); m_bus.out_ready = 1'b1;
        tick();
        check("rf_b1_data", m_bus.out_data, pay(32'hE000_0000, 1));
        m_bus.in_valid = 1'b0;
        tick();
        check("rf_b1_only", WIDTH'(m_bus.out_valid), '0);

        // ---------------- stall counter saturation (CNT_W=4) ----------------
        s_reset = 1'b1; s_bus.in_valid = 1'b1; s_bus.in_data = pay(32'hF000_0000, 1);
        tick();                                            // ONE, no stall yet
        check("sat_start", WIDTH'(s_cnt), '0);
        s_bus.in_valid = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        check("sat_mid", WIDTH'(s_cnt), WIDTH'(10));
        for (int i = 0; i < 10; i++) tick();
        check("sat_top", WIDTH'(s_cnt), WIDTH'(15));
        s_flush = 1'b1;
        tick();
        check("sat_flush_cnt",   WIDTH'(s_cnt), WIDTH'(15));
        check("sat_flush_valid", WIDTH'(s_bus.out_valid), '0);
        s_flush = 1'b0;
        tick();
        check("sat_hold", WIDTH'(s_cnt), WIDTH'(15));
        s_reset = 1'b0;
        tick();
        check("sat_reset", WIDTH'(s_cnt), '0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/pipe_skid_stage.md
Name: pipe_skid_stage

Overview:
- Parametrised successor to the fixed five-field inter-stage pipeline register (IF/ID, ID/EX, EX/MEM, MEM/WB).
- Adds a valid/ready handshake, a 2-entry skid buffer and a synchronous flush, so a stall propagates backward one stage per cycle without a combinational ready path.
- Sits between any two pipeline stages; the stage's fields are carried as one concatenated bus.
- Keeps a saturating back-pressure counter for performance debug.

Parameters:
- WIDTH, 160, width of the concatenated payload (default is 5 x 32: Inst, rs, rt, imm, DO).
- BUBBLE, 0, value driven on out_data whenever the stage holds no valid entry (0 = sll $0,$0,0 nop encoding in the Inst field).
- CNT_W, 16, width of the stall counter.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-low reset.
- flush  in  1  synchronous kill of all held entries (branch/exception squash).
- in_valid  in  1  upstream has a payload.
- in_ready  out  1  stage can accept; registered, not combinationally dependent on out_ready.
- in_data  in  WIDTH  upstream payload.
- out_valid  out  1  out_data is a valid payload.
- out_ready  in  1  downstream accepts this cycle.
- out_data  out  WIDTH  payload to downstream; registered.
- stall_cnt  out  CNT_W  cycles with out_valid=1 and out_ready=0, saturating.

Behaviour:
- Transfers: accept = in_valid & in_ready; emit = out_valid & out_ready.
- Storage: main register (M, drives out_data/out_valid) and skid register (S).
- States and outputs:
  - EMPTY: out_valid=0, in_ready=1.
  - ONE: M valid, out_valid=1, in_ready=1.
  - FULL: M and S valid, out_valid=1, in_ready=0.
- Transitions:
  - EMPTY & accept -> ONE; M<=in_data.
  - ONE & accept & emit -> ONE; M<=in_data.
  - ONE & accept & !emit -> FULL; S<=in_data.
  - ONE & !accept & emit -> EMPTY; M<=BUBBLE.
  - FULL & emit -> ONE; M<=S, S<=BUBBLE. No accept is possible while FULL.
  - All other combinations: hold.
- Latency: 1 cycle from accept in EMPTY, or in ONE with emit, to out_valid. Order is strictly FIFO; no payload is dropped or duplicated.
- Reset (reset=0 at a clk edge): state EMPTY; M=S=BUBBLE; out_valid=0; in_ready=1; stall_cnt=0. Reset overrides flush and all handshakes.
- Reset asserted mid-transfer discards both entries. The first accept after release occurs on the first edge with reset=1.
- Flush (reset=1, flush=1): next state EMPTY; M=S=BUBBLE; in_ready=1 next cycle.
  - An accept in the same cycle is discarded. An emit in the same cycle still counts downstream, since out_data was valid that cycle.
  - stall_cnt is unaffected by flush.
- stall_cnt increments by 1 on each edge where out_valid=1 and out_ready=0, saturates at 2^CNT_W-1, and clears only on reset.
- in_valid=1 while in_ready=0: upstream holds its data; the stage ignores it.
- out_data is BUBBLE whenever out_valid=0. in_data content when in_valid=0 is ignored.

Test Plan:
- Reset: reset=0 for 2 cycles, in_valid=1 -> out_valid=0, out_data=0, in_ready=1, stall_cnt=0; first accept occurs on the first edge after reset=1.
- Streaming: out_ready=1, push A1..A8 back-to-back -> out_data=A1..A8 one per cycle, 1-cycle latency, in_ready stays 1.
- Back-pressure: push A1, A2, A3 with out_ready=0 from the cycle A1 appears -> A1 held, A2 in skid, in_ready=0, A3 held upstream; raise out_ready -> A1, A2, A3 in order, no loss; stall_cnt equals the stalled cycle count.
- Flush in FULL: A1 in M, A2 in S, flush=1 with in_valid=1 (A3) -> next cycle out_valid=0, out_data=BUBBLE, in_ready=1, A3 never appears.
- Saturation: CNT_W=4, out_ready=0 for 20 cycles with a valid entry -> stall_cnt stops at 15; flush -> still 15; reset -> 0.
- Reset mid-FULL: A1/A2 held, reset=0 one cycle -> EMPTY; after release push B1 -> out_data=B1 only.
